shift_sequencer: RTL

- Bit-serial shift controller for the ALU shift datapath.
- Accepts one shift request (operand, amount, direction, fill bit) and performs it one bit position per clock, tracking the last bit shifted out.
- Returns the result with a one-cycle done pulse; sits between the ALU operation decoder and the result mux.
- Replaces a wide barrel shifter with a small counter plus FSM.

---
 rtl/shift_sequencer.sv | 110 +++++++++++
 1 files changed

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - bit-serial shifter: one bit position per clock, done pulse on completion
// Optional feature: define SHIFT_ROTATE_EN to add the rot input (rotate instead of fill).
module shift_sequencer #(
  parameter int ancho = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [ancho-1:0] a,
  input  logic [ancho-1:0] b,
  input  logic             dir,
  input  logic             aluflagin,
`ifdef SHIFT_ROTATE_EN
  input  logic             rot,
`endif
  output logic             busy,
  output logic             done,
  output logic [ancho-1:0] aluresult,
  output logic             aluflags
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [ancho-1:0] one = ancho'(1);

  state_t           state, state_nxt;
  logic [ancho-1:0] work, work_nxt;
  logic [ancho-1:0] count, count_nxt;
  logic             out_q, out_nxt;
  logic             dir_q, fill_q;
  logic             shbit, fillbit;
`ifdef SHIFT_ROTATE_EN
  logic             rot_q;
`endif

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // The bit leaving the register this step; a rotate feeds it straight back in.
  assign shbit = dir_q ? work[0] : work[ancho-1];
`ifdef SHIFT_ROTATE_EN
  assign fillbit = rot_q ? shbit : fill_q;
`else
  assign fillbit = fill_q;
`endif

  always_comb begin
    state_nxt = state;
    work_nxt  = work;
    count_nxt = count;
    out_nxt   = out_q;
    case (state)
      IDLE: begin
        if (start) begin
          work_nxt  = a;
          count_nxt = b;
          out_nxt   = 1'b0;
          state_nxt = (b != '0) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        out_nxt   = shbit;
        work_nxt  = dir_q ? {fillbit, work[ancho-1:1]} : {work[ancho-2:0], fillbit};
        count_nxt = count - one;
        // count is never zero here, so checking for one avoids any underflow.
        if (count == one) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      work      <= '0;
      count     <= '0;
      out_q     <= 1'b0;
      dir_q     <= 1'b0;
      fill_q    <= 1'b0;
`ifdef SHIFT_ROTATE_EN
      rot_q     <= 1'b0;
`endif
      aluresult <= '0;
      aluflags  <= 1'b0;
    end else begin
      state <= state_nxt;
      work  <= work_nxt;
      count <= count_nxt;
      out_q <= out_nxt;
      if (state == IDLE && start) begin
        dir_q  <= dir;
        fill_q <= aluflagin;
`ifdef SHIFT_ROTATE_EN
        rot_q  <= rot;
`endif
      end
      // Results are registered on the edge that enters DONE and held until the next one.
      if (state != DONE && state_nxt == DONE) begin
        aluresult <= work_nxt;
        aluflags  <= out_nxt;
      end
    end
  end

endmodule
